// File: rtl/vigna_pkg.sv
// Shared definitions for the vigna memory bus: arbiter state encoding, arbitration modes, bus widths.
package vigna_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

endpackage

// File: rtl/vigna_bus_arbiter_if.sv
// One valid/ready memory bus port; master issues requests, slave completes them with a ready pulse.
interface vigna_bus_arbiter_if;
  import vigna_pkg::*;

  logic              valid;
  logic              ready;
  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] rdata;
  logic [BUS_DW-1:0] wdata;
  logic [BUS_SW-1:0] wstrb;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/vigna_arb2.sv
// Combinational two-way grant picker: bit 0 is the instruction port, bit 1 the data port.
module vigna_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] gnt
);

  // Under contention: fixed mode always favours data; round-robin favours whoever did not win last.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (mode || !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// Merges the vigna instruction and data ports onto one slave port; the grant is registered,
// the granted master's request and the slave's ready are passed through combinationally.
module vigna_bus_arbiter
  import vigna_pkg::*;
#(
  parameter int ARB_MODE   = ARB_RR,
  parameter bit RESET_LAST = 1'b1
) (
  input logic                 clk,
  input logic                 resetn,
  vigna_bus_arbiter_if.slave  i_bus,
  vigna_bus_arbiter_if.slave  d_bus,
  vigna_bus_arbiter_if.master s_bus
);

  localparam bit FIXED_MODE = (ARB_MODE == ARB_FIXED);

  arb_state_t state;
  logic       last;
  logic [1:0] gnt;

  vigna_arb2 u_arb2 (
    .req  ({d_bus.valid, i_bus.valid}),
    .last (last),
    .mode (FIXED_MODE),
    .gnt  (gnt)
  );

  // A completion or a withdrawn request both return to IDLE, which forces the turnaround cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ARB_IDLE;
      last  <= RESET_LAST;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt[0]) begin
            state <= ARB_GNT_I;
            last  <= 1'b0;
          end else if (gnt[1]) begin
            state <= ARB_GNT_D;
            last  <= 1'b1;
          end
        end
        ARB_GNT_I: if (s_bus.ready || !i_bus.valid) state <= ARB_IDLE;
        ARB_GNT_D: if (s_bus.ready || !d_bus.valid) state <= ARB_IDLE;
        default:   state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_bus.valid = 1'b0;
    s_bus.addr  = '0;
    s_bus.wdata = '0;
    s_bus.wstrb = '0;
    i_bus.ready = 1'b0;
    d_bus.ready = 1'b0;
    case (state)
      ARB_GNT_I: begin
        s_bus.valid = i_bus.valid;
        s_bus.addr  = i_bus.addr;
        s_bus.wdata = i_bus.wdata;
        s_bus.wstrb = i_bus.wstrb;
        i_bus.ready = s_bus.ready;
      end
      ARB_GNT_D: begin
        s_bus.valid = d_bus.valid;
        s_bus.addr  = d_bus.addr;
        s_bus.wdata = d_bus.wdata;
        s_bus.wstrb = d_bus.wstrb;
        d_bus.ready = s_bus.ready;
      end
      default: ;
    endcase
  end

  // Read data is shared; each master qualifies it with its own ready pulse.
  assign i_bus.rdata = s_bus.rdata;
  assign d_bus.rdata = s_bus.rdata;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench: a per-cycle vector table on a round-robin instance, plus short hand sequences
// for mid-transfer reset and a fixed-priority instance.
module tb_vigna_bus_arbiter;
  import vigna_pkg::*;

  logic clk = 1'b0;
  logic resetn0;
  logic resetn1;
  always #5 clk = ~clk;

  vigna_bus_arbiter_if ib0 ();
  vigna_bus_arbiter_if db0 ();
  vigna_bus_arbiter_if sb0 ();
  vigna_bus_arbiter_if ib1 ();
  vigna_bus_arbiter_if db1 ();
  vigna_bus_arbiter_if sb1 ();

  vigna_bus_arbiter #(.ARB_MODE(ARB_RR), .RESET_LAST(1'b1)) dut0 (
    .clk(clk), .resetn(resetn0), .i_bus(ib0), .d_bus(db0), .s_bus(sb0)
  );

  vigna_bus_arbiter #(.ARB_MODE(ARB_FIXED), .RESET_LAST(1'b1)) dut1 (
    .clk(clk), .resetn(resetn1), .i_bus(ib1), .d_bus(db1), .s_bus(sb1)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic        sr;
    logic [31:0] srd;
    logic        chk;
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sw;
    logic [3:0]  ss;
    logic        ir;
    logic        dr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic iv, input logic [31:0] ia,
                     input logic dv, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                     input logic sr, input logic [31:0] srd, input logic ck,
                     input logic sv, input logic [31:0] sa, input logic [31:0] sw, input logic [3:0] ss,
                     input logic ir, input logic dr);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.ds = ds;
    v.sr = sr; v.srd = srd; v.chk = ck;
    v.sv = sv; v.sa = sa; v.sw = sw; v.ss = ss; v.ir = ir; v.dr = dr;
    tbl.push_back(v);
  endtask

  task automatic drive0(input logic rst, input logic iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                        input logic sr, input logic [31:0] srd);
    resetn0 = rst;
    ib0.valid = iv; ib0.addr = ia; ib0.wdata = 32'h0; ib0.wstrb = 4'h0;
    db0.valid = dv; db0.addr = da; db0.wdata = dw; db0.wstrb = ds;
    sb0.ready = sr; sb0.rdata = srd;
  endtask

  task automatic drive1(input logic rst, input logic iv, input logic [31:0] ia,
                        input logic dv, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                        input logic sr, input logic [31:0] srd);
    resetn1 = rst;
    ib1.valid = iv; ib1.addr = ia; ib1.wdata = 32'h0; ib1.wstrb = 4'h0;
    db1.valid = dv; db1.addr = da; db1.wdata = dw; db1.wstrb = ds;
    sb1.ready = sr; sb1.rdata = srd;
  endtask

  task automatic check0(input string t, input logic sv, input logic [31:0] sa, input logic [31:0] sw,
                        input logic [3:0] ss, input logic ir, input logic dr, input logic [31:0] rd);
    chk({t, ".s_valid"}, 32'(sb0.valid), 32'(sv));
    chk({t, ".s_addr"},  sb0.addr, sa);
    chk({t, ".s_wdata"}, sb0.wdata, sw);
    chk({t, ".s_wstrb"}, 32'(sb0.wstrb), 32'(ss));
    chk({t, ".i_ready"}, 32'(ib0.ready), 32'(ir));
    chk({t, ".d_ready"}, 32'(db0.ready), 32'(dr));
    chk({t, ".i_rdata"}, ib0.rdata, rd);
    chk({t, ".d_rdata"}, db0.rdata, rd);
  endtask

  task automatic check1(input string t, input logic sv, input logic [31:0] sa, input logic [31:0] sw,
                        input logic [3:0] ss, input logic ir, input logic dr, input logic [31:0] rd);
    chk({t, ".s_valid"}, 32'(sb1.valid), 32'(sv));
    chk({t, ".s_addr"},  sb1.addr, sa);
    chk({t, ".s_wdata"}, sb1.wdata, sw);
    chk({t, ".s_wstrb"}, 32'(sb1.wstrb), 32'(ss));
    chk({t, ".i_ready"}, 32'(ib1.ready), 32'(ir));
    chk({t, ".d_ready"}, 32'(db1.ready), 32'(dr));
    chk({t, ".i_rdata"}, ib1.rdata, rd);
  endtask

  initial begin
    drive0(1'b0, 1'b1, 32'h100, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3, 1'b0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    // Reset held with both masters requesting, then first contended grant goes to instruction.
    add(0, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    add(0, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    add(0, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    add(1, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    // Instruction read, slave answers two cycles after s_valid.
    add(1, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 1, 32'h100, 32'h0, 4'h0, 0, 0);
    add(1, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 1, 32'h100, 32'h0, 4'h0, 0, 0);
    add(1, 1, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'h13, 1, 1, 32'h100, 32'h0, 4'h0, 1, 0);
    // Turnaround, then the waiting store goes through.
    add(1, 0, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    add(1, 0, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0);
    add(1, 0, 32'h100, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'hCAFE0001, 1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 1);
    // s_ready while idle must not reach either master.
    add(1, 0, 32'h100, 0, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    // Data request withdrawn before the slave answers.
    add(1, 0, 32'h0, 1, 32'h40, 32'h55, 4'hF, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    add(1, 0, 32'h0, 1, 32'h40, 32'h55, 4'hF, 0, 32'h0, 1, 1, 32'h40, 32'h55, 4'hF, 0, 0);
    add(1, 0, 32'h0, 0, 32'h40, 32'h55, 4'hF, 0, 32'h0, 1, 0, 32'h40, 32'h55, 4'hF, 0, 0);
    add(1, 0, 32'h0, 0, 32'h40, 32'h55, 4'hF, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    // Both masters always requesting, zero-wait slave: I, D, I, D... with an idle cycle between.
    for (int k = 0; k < 4; k++) begin
      add(1, 1, 32'h200, 1, 32'h300, 32'h11, 4'h8, 1, 32'hA0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
      add(1, 1, 32'h200, 1, 32'h300, 32'h11, 4'h8, 1, 32'hA0, 1, 1, 32'h200, 32'h0, 4'h0, 1, 0);
      add(1, 1, 32'h200, 1, 32'h300, 32'h11, 4'h8, 1, 32'hA0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
      add(1, 1, 32'h200, 1, 32'h300, 32'h11, 4'h8, 1, 32'hA0, 1, 1, 32'h300, 32'h11, 4'h8, 0, 1);
    end
    add(1, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive0(tbl[i].rst, tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].da, tbl[i].dw, tbl[i].ds,
             tbl[i].sr, tbl[i].srd);
      #1;
      if (tbl[i].chk) begin
        check0($sformatf("row%0d", i), tbl[i].sv, tbl[i].sa, tbl[i].sw, tbl[i].ss,
               tbl[i].ir, tbl[i].dr, tbl[i].srd);
      end
    end

    // Reset during a granted transfer aborts it; a late s_ready is ignored.
    @(negedge clk); drive0(1, 1, 32'h500, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0); #1;
    check0("abort.idle", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive0(0, 1, 32'h500, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0); #1;
    check0("abort.gnt", 1, 32'h500, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive0(1, 0, 32'h500, 0, 32'h0, 32'h0, 4'h0, 1, 32'h77); #1;
    check0("abort.late", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h77);
    @(negedge clk); drive0(1, 0, 32'h500, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0); #1;
    check0("abort.after", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);

    // Fixed priority: data wins contention even when it won last time.
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h700, 32'h77, 4'h1, 0, 32'h0); #1;
    check1("fix.idle0", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h700, 32'h77, 4'h1, 1, 32'h99); #1;
    check1("fix.d0", 1, 32'h700, 32'h77, 4'h1, 0, 1, 32'h99);
    @(negedge clk); drive1(1, 1, 32'h600, 0, 32'h700, 32'h77, 4'h1, 0, 32'h0); #1;
    check1("fix.idle1", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive1(1, 1, 32'h600, 0, 32'h700, 32'h77, 4'h1, 1, 32'h13); #1;
    check1("fix.i0", 1, 32'h600, 32'h0, 4'h0, 1, 0, 32'h13);
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h704, 32'h78, 4'h2, 0, 32'h0); #1;
    check1("fix.idle2", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h704, 32'h78, 4'h2, 1, 32'h5); #1;
    check1("fix.d1", 1, 32'h704, 32'h78, 4'h2, 0, 1, 32'h5);
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h708, 32'h79, 4'h4, 0, 32'h0); #1;
    check1("fix.idle3", 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    @(negedge clk); drive1(1, 1, 32'h600, 1, 32'h708, 32'h79, 4'h4, 1, 32'h6); #1;
    check1("fix.d2", 1, 32'h708, 32'h79, 4'h4, 0, 1, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
